pipe_stage_reg: RTL

- Parametrised inter-stage pipeline register, the generalised successor of the fixed ID/EX latch.
- Carries one data bundle (DATA_W) and one control bundle (CTRL_W) between two stages, with valid/ready handshake, stall, flush-to-bubble and an optional 2-entry skid buffer.
- Used for IF/ID, ID/EX, EX/MEM and MEM/WB by changing parameters; exports a saturating stall counter for performance debug.

---
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
// Carries a data bundle and a control bundle between two pipeline stages.
// The register uses a valid/ready handshake and supports stall and flush-to-bubble.
// An optional 2-entry skid buffer decouples in_ready from out_ready.
// A saturating stall counter is exported for performance debug.
module pipe_stage_reg #(
    parameter int                DATA_W      = 104,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                SKID        = 1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_emit;

    assign w_accept  = in_valid & w_in_ready;
    assign w_emit    = r_out_valid & out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ctrl  = r_out_ctrl;
    assign stall_cnt = r_stall_cnt;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_skid_valid;
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;

            // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
            assign w_in_ready = ~r_skid_valid;

            // The output slot refills from the skid first (oldest beat), then from the input.
            // A beat that arrives while the output is stalled is parked in the skid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_valid  <= 1'b0;
                    r_out_data   <= '0;
                    r_out_ctrl   <= BUBBLE_CTRL;
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                    r_skid_ctrl  <= '0;
                end else if (flush) begin
                    r_out_valid  <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_out_ctrl   <= BUBBLE_CTRL;
                end else if (!r_out_valid || w_emit) begin
                    if (r_skid_valid) begin
                        r_out_valid  <= 1'b1;
                        r_out_data   <= r_skid_data;
                        r_out_ctrl   <= r_skid_ctrl;
                        r_skid_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= in_data;
                        r_out_ctrl  <= in_ctrl;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end else if (w_accept) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= in_data;
                    r_skid_ctrl  <= in_ctrl;
                end
            end
        end else begin : g_noskid
            // The stage can take a beat whenever the current one leaves or there is none.
            assign w_in_ready = out_ready | ~r_out_valid;

            // Single output register. When a beat leaves, its data and ctrl stay as they are.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_out_ctrl  <= BUBBLE_CTRL;
                end else if (flush) begin
                    r_out_valid <= 1'b0;
                    r_out_ctrl  <= BUBBLE_CTRL;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= in_data;
                    r_out_ctrl  <= in_ctrl;
                end else if (w_emit) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    endgenerate

    // Count stalled cycles. The count saturates and is cleared only by reset, not by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

endmodule
